ysyx_mul_issue_ctrl: RTL and testbench

Issue and writeback controller placed in front of the sequential 64×64 Booth multiplier core. It accepts RISC-V M-extension multiply ops (MUL/MULH/MULHSU/MULHU/MULW) over a valid/ready handshake and derives the operand signedness. It holds the core's level-sensitive `mul_valid` for the whole computation and aborts the core safely on flush. On completion it selects and sign-extends the 64-bit result from the 128-bit product and presents it to writeback over a second valid/ready handshake.

---
 rtl/ysyx_mul_issue_ctrl_pkg.sv | 27 ++
 rtl/ysyx_mul_issue_ctrl_if.sv | 24 ++
 rtl/ysyx_mul_result_sel.sv | 20 ++
 rtl/ysyx_mul_issue_ctrl.sv | 150 +++++++++++++++
 tb/tb_ysyx_mul_issue_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_mul_issue_ctrl_pkg.sv
// rtl/ysyx_mul_issue_ctrl_pkg.sv - shared constants for the multiplier issue controller
// Op encoding, FSM state encoding and operand-signedness decode.
package ysyx_mul_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] MUL_OP_MUL    = 3'd0;
  localparam logic [2:0] MUL_OP_MULH   = 3'd1;
  localparam logic [2:0] MUL_OP_MULHSU = 3'd2;
  localparam logic [2:0] MUL_OP_MULHU  = 3'd3;
  localparam logic [2:0] MUL_OP_MULW   = 3'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Returns {rs1_signed, rs2_signed}; undefined ops behave as MUL.
  function automatic logic [1:0] op_signedness(input logic [2:0] op);
    case (op)
      MUL_OP_MULH:   return 2'b11;
      MUL_OP_MULHSU: return 2'b10;
      default:       return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_mul_issue_ctrl_if.sv
// rtl/ysyx_mul_issue_ctrl_if.sv - link between the issue controller and the Booth multiplier core
// master = controller side, slave = core side.
interface ysyx_mul_issue_ctrl_if;
  import ysyx_mul_pkg::*;

  logic                mul_valid;
  logic                mul_rs1_signed;
  logic                mul_rs2_signed;
  logic [XLEN-1:0]     mul_rs1;
  logic [XLEN-1:0]     mul_rs2;
  logic                mul_ready;
  logic [2*XLEN-1:0]   mul_out;

  modport master (
    output mul_valid, mul_rs1_signed, mul_rs2_signed, mul_rs1, mul_rs2,
    input  mul_ready, mul_out
  );

  modport slave (
    input  mul_valid, mul_rs1_signed, mul_rs2_signed, mul_rs1, mul_rs2,
    output mul_ready, mul_out
  );

endinterface

// File: rtl/ysyx_mul_result_sel.sv
// rtl/ysyx_mul_result_sel.sv - picks and sign-extends the 64-bit result from a 128-bit product
// Purely combinational; shared by the core path and the stored-product path.
module ysyx_mul_result_sel
  import ysyx_mul_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0]   result
);

  always_comb begin
    result = prod[XLEN-1:0];
    case (op)
      MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU: result = prod[2*XLEN-1:XLEN];
      MUL_OP_MULW:                              result = {{32{prod[31]}}, prod[31:0]};
      default:                                  result = prod[XLEN-1:0];
    endcase
  end

endmodule

// File: rtl/ysyx_mul_issue_ctrl.sv
// rtl/ysyx_mul_issue_ctrl.sv - issue/writeback controller for the sequential Booth multiplier
// Optional product reuse for identical back-to-back operands is enabled by MUL_RESULT_REUSE_EN.
module ysyx_mul_issue_ctrl
  import ysyx_mul_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [2:0]           op_i,
  input  logic [XLEN-1:0]      rs1_i,
  input  logic [XLEN-1:0]      rs2_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [XLEN-1:0]      rd_data_o,
  ysyx_mul_issue_ctrl_if.master core
);

  logic [1:0]      state_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic            rs1_signed_q;
  logic            rs2_signed_q;
  logic [XLEN-1:0] rd_data_q;
  logic            drain_q;

  logic [1:0]      sgn_in;
  logic            accept;
  logic            reuse_hit;
  logic [XLEN-1:0] reuse_res;
  logic [XLEN-1:0] core_res;

  assign sgn_in = op_signedness(op_i);
  assign accept = (state_q == ST_IDLE) && in_valid_i && !flush_i;

  ysyx_mul_result_sel u_core_sel (
    .op     (op_q),
    .prod   (core.mul_out),
    .result (core_res)
  );

`ifdef MUL_RESULT_REUSE_EN
  logic [XLEN-1:0]   last_rs1_q;
  logic [XLEN-1:0]   last_rs2_q;
  logic              last_s1_q;
  logic              last_s2_q;
  logic [2*XLEN-1:0] last_prod_q;
  logic              reuse_vld_q;

  assign reuse_hit = reuse_vld_q && (rs1_i == last_rs1_q) && (rs2_i == last_rs2_q)
                     && (sgn_in == {last_s1_q, last_s2_q});

  ysyx_mul_result_sel u_reuse_sel (
    .op     (op_i),
    .prod   (last_prod_q),
    .result (reuse_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last_rs1_q  <= '0;
      last_rs2_q  <= '0;
      last_s1_q   <= 1'b0;
      last_s2_q   <= 1'b0;
      last_prod_q <= '0;
      reuse_vld_q <= 1'b0;
    end else if (state_q == ST_BUSY) begin
      if (flush_i) begin
        reuse_vld_q <= 1'b0;
      end else if (core.mul_ready) begin
        last_rs1_q  <= rs1_q;
        last_rs2_q  <= rs2_q;
        last_s1_q   <= rs1_signed_q;
        last_s2_q   <= rs2_signed_q;
        last_prod_q <= core.mul_out;
        reuse_vld_q <= 1'b1;
      end
    end
  end
`else
  assign reuse_hit = 1'b0;
  assign reuse_res = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= MUL_OP_MUL;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rs1_signed_q <= 1'b0;
      rs2_signed_q <= 1'b0;
      rd_data_q    <= '0;
      drain_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q         <= op_i;
            rs1_q        <= rs1_i;
            rs2_q        <= rs2_i;
            rs1_signed_q <= sgn_in[1];
            rs2_signed_q <= sgn_in[0];
            if (reuse_hit) begin
              rd_data_q <= reuse_res;
              state_q   <= ST_DONE;
            end else begin
              state_q   <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          // Flush wins over a coincident done pulse: the result is dropped.
          if (flush_i) begin
            drain_q <= 1'b0;
            state_q <= ST_DRAIN;
          end else if (core.mul_ready) begin
            rd_data_q <= core_res;
            state_q   <= ST_DONE;
          end
        end
        ST_DRAIN: begin
          // Two dead cycles swallow any stale done pulse from the aborted core.
          drain_q <= 1'b1;
          if (drain_q) begin
            drain_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (flush_i || out_ready_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready_o          = (state_q == ST_IDLE);
  assign out_valid_o         = (state_q == ST_DONE);
  assign rd_data_o           = rd_data_q;
  // Dropped in the pulse cycle so the level-sensitive core does not restart.
  assign core.mul_valid      = (state_q == ST_BUSY) && !core.mul_ready;
  assign core.mul_rs1        = rs1_q;
  assign core.mul_rs2        = rs2_q;
  assign core.mul_rs1_signed = rs1_signed_q;
  assign core.mul_rs2_signed = rs2_signed_q;

endmodule

// File: tb/tb_ysyx_mul_issue_ctrl.sv
// tb/tb_ysyx_mul_issue_ctrl.sv - directed bench for ysyx_mul_issue_ctrl with a 37-cycle core model
// Expected results are hand-computed constants.
module tb_ysyx_mul_issue_ctrl;
  import ysyx_mul_pkg::*;

`ifdef MUL_RESULT_REUSE_EN
  localparam int HIT_LAT = 1;
  localparam int HIT_MV  = 0;
`else
  localparam int HIT_LAT = 38;
  localparam int HIT_MV  = 36;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] rd_data;

  int n_checks = 0;
  int n_pass   = 0;
  int core_cnt;

  ysyx_mul_issue_ctrl_if core_if ();

  ysyx_mul_issue_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .flush_i     (flush),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .rd_data_o   (rd_data),
    .core        (core_if)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] core_prod(input logic [63:0] a, input logic [63:0] b,
                                             input logic sa, input logic sb);
    logic [127:0] ea;
    logic [127:0] eb;
    ea = sa ? {{64{a[63]}}, a} : {64'b0, a};
    eb = sb ? {{64{b[63]}}, b} : {64'b0, b};
    return ea * eb;
  endfunction

  // Core model: done pulse after 36 cycles of continuous mul_valid; abort when it drops.
  always @(posedge clk) begin
    if (rst) begin
      core_cnt          <= 0;
      core_if.mul_ready <= 1'b0;
      core_if.mul_out   <= '0;
    end else if (core_if.mul_ready) begin
      core_if.mul_ready <= 1'b0;
      core_cnt          <= 0;
    end else if (core_if.mul_valid) begin
      if (core_cnt == 35) begin
        core_if.mul_ready <= 1'b1;
        core_if.mul_out   <= core_prod(core_if.mul_rs1, core_if.mul_rs2,
                                       core_if.mul_rs1_signed, core_if.mul_rs2_signed);
        core_cnt          <= 0;
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end else begin
      core_cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input logic es1,
                       input logic es2, input int exp_lat, input int exp_mv, input int hold);
    int   n;
    int   mv;
    int   rise;
    logic prev;
    logic s1;
    logic s2;
    @(negedge clk);
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    op       = o;
    rs1      = a;
    rs2      = b;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1; mv = 0; rise = 0; prev = 1'b0;
    s1 = core_if.mul_rs1_signed;
    s2 = core_if.mul_rs2_signed;
    while (!out_valid && n < 200) begin
      if (core_if.mul_valid) mv++;
      if (core_if.mul_valid && !prev) rise++;
      prev = core_if.mul_valid;
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, 64'(n), 64'(exp_lat));
    check({tag, ".mul_valid_cycles"}, 64'(mv), 64'(exp_mv));
    check({tag, ".mul_valid_starts"}, 64'(rise), (exp_mv > 0) ? 64'd1 : 64'd0);
    check({tag, ".rs1_signed"}, 64'(s1), 64'(es1));
    check({tag, ".rs2_signed"}, 64'(s2), 64'(es2));
    check({tag, ".rd_data"}, rd_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_out_valid"}, 64'(out_valid), 64'd1);
      check({tag, ".hold_no_restart"}, 64'(core_if.mul_valid), 64'd0);
      check({tag, ".hold_rd_data"}, rd_data, exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".idle_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, ".idle_out_valid"}, 64'(out_valid), 64'd0);
  endtask

  task automatic flush_op(input string tag, input logic [2:0] o, input logic [63:0] a,
                          input logic [63:0] b, input int fat);
    int n;
    int ov;
    @(negedge clk);
    in_valid = 1'b1;
    op       = o;
    rs1      = a;
    rs2      = b;
    @(negedge clk);
    in_valid = 1'b0;
    n  = 1;
    ov = 0;
    while (n < fat) begin
      if (out_valid) ov++;
      @(negedge clk);
      n++;
    end
    check({tag, ".mul_valid_at_flush"}, 64'(core_if.mul_valid), (fat == 37) ? 64'd0 : 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n++;
    check({tag, ".mul_valid_after_flush"}, 64'(core_if.mul_valid), 64'd0);
    while (!in_ready && n < fat + 50) begin
      if (out_valid) ov++;
      @(negedge clk);
      n++;
    end
    check({tag, ".in_ready_delay"}, 64'(n - fat), 64'd3);
    check({tag, ".no_out_valid"}, 64'(ov), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 3'd0; rs1 = '0; rs2 = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.in_ready", 64'(in_ready), 64'd1);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.mul_valid", 64'(core_if.mul_valid), 64'd0);
    check("reset.rd_data", rd_data, 64'd0);
    check("reset.mul_rs1", core_if.mul_rs1, 64'd0);
    check("reset.mul_rs2", core_if.mul_rs2, 64'd0);
    rst = 1'b0;

    do_op("mul_3x5", MUL_OP_MUL, 64'd3, 64'd5, 64'hF, 1'b0, 1'b0, 38, 36, 3);
    do_op("mulh_m1", MUL_OP_MULH, '1, '1, 64'd0, 1'b1, 1'b1, 38, 36, 0);
    do_op("mulhu_max", MUL_OP_MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 38, 36, 0);
    do_op("mulhsu_m1x2", MUL_OP_MULHSU, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 38, 36, 0);
    do_op("mulw", MUL_OP_MULW, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 38, 36, 0);
    do_op("op7_as_mul", 3'd7, 64'd11, 64'd13, 64'd143, 1'b0, 1'b0, 38, 36, 0);

    do_op("mulhu_ab", MUL_OP_MULHU, 64'h1_0000_0003, 64'h2_0000_0005, 64'd2, 1'b0, 1'b0, 38, 36, 0);
    do_op("mul_ab_reuse", MUL_OP_MUL, 64'h1_0000_0003, 64'h2_0000_0005, 64'h0000_000B_0000_000F,
          1'b0, 1'b0, HIT_LAT, HIT_MV, 1);

    flush_op("flush_busy10", MUL_OP_MUL, 64'd9, 64'd9, 10);
    do_op("mul_ab_after_flush", MUL_OP_MUL, 64'h1_0000_0003, 64'h2_0000_0005,
          64'h0000_000B_0000_000F, 1'b0, 1'b0, 38, 36, 0);
    flush_op("flush_on_ready", MUL_OP_MUL, 64'd9, 64'd9, 37);
    do_op("mul_7x6", MUL_OP_MUL, 64'd7, 64'd6, 64'd42, 1'b0, 1'b0, 38, 36, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
